// File: rtl/instr_queue_splitter.sv
// Fetch-to-decode instruction queue: circular FIFO of {PC, instr} pairs with head field split and immediate extension.
// Optional build macro INSTR_QUEUE_CLASSIFY_EN adds is_rtype/is_jtype/is_itype head classification outputs.
module instr_queue_splitter #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EXT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [1:0]               ext_op,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic [5:0]               op,
    output logic [5:0]               funct,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [15:0]              imm16,
    output logic [EXT_W-1:0]         imm_ext,
    output logic [25:0]              jidx,
`ifdef INSTR_QUEUE_CLASSIFY_EN
    output logic                     is_rtype,
    output logic                     is_jtype,
    output logic                     is_itype,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    // Elaboration-time guard on parameter legality.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_queue_splitter: DEPTH must be a power of two >= 2");
    end
    if (EXT_W < 16) begin : g_bad_ext
        $error("instr_queue_splitter: EXT_W must be >= 16");
    end

    logic [PC_W-1:0]   r_mem_pc    [DEPTH];
    logic [31:0]       r_mem_instr [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [PC_W-1:0]   w_head_pc;
    logic [31:0]       w_head_instr;
    logic [15:0]       w_imm16;
    logic [EXT_W-1:0]  w_imm_zero;
    logic [EXT_W-1:0]  w_imm_sign;
    logic [EXT_W-1:0]  w_imm_upper;

    // Handshake status comes only from registered occupancy, so out_ready never reaches in_ready.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == CNT_W'(0));
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = ~w_empty & out_ready;

    // Storage is cleared only by reset; flush leaves stale contents in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem_pc[r_wptr]    <= in_pc;
            r_mem_instr[r_wptr] <= in_instr;
        end
    end

    // Pointers wrap through the power-of-two range; flush overrides any same-cycle push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_pc    = r_mem_pc[r_rptr];
    assign w_head_instr = r_mem_instr[r_rptr];
    assign w_imm16      = w_head_instr[15:0];

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign count     = r_count;

    assign out_pc    = w_head_pc;
    assign out_instr = w_head_instr;
    assign op        = w_head_instr[31:26];
    assign rs        = w_head_instr[25:21];
    assign rt        = w_head_instr[20:16];
    assign rd        = w_head_instr[15:11];
    assign shamt     = w_head_instr[10:6];
    assign funct     = w_head_instr[5:0];
    assign imm16     = w_imm16;
    assign jidx      = w_head_instr[25:0];

    assign w_imm_zero = EXT_W'(w_imm16);
    assign w_imm_sign = EXT_W'($signed(w_imm16));

    // Upper mode needs room for bits [31:16]; narrower outputs fall back to zero-extension.
    if (EXT_W >= 32) begin : g_upper
        assign w_imm_upper = EXT_W'({w_imm16, 16'h0000});
    end else begin : g_upper_narrow
        assign w_imm_upper = w_imm_zero;
    end

    always_comb begin
        imm_ext = w_imm_zero;
        case (ext_op)
            EXT_ZERO:  imm_ext = w_imm_zero;
            EXT_SIGN:  imm_ext = w_imm_sign;
            EXT_UPPER: imm_ext = w_imm_upper;
            default:   imm_ext = w_imm_zero;
        endcase
    end

`ifdef INSTR_QUEUE_CLASSIFY_EN
    logic w_op_r;
    logic w_op_j;

    assign w_op_r   = (w_head_instr[31:26] == 6'h00);
    assign w_op_j   = (w_head_instr[31:26] == 6'h02) || (w_head_instr[31:26] == 6'h03);
    assign is_rtype = ~w_empty & w_op_r;
    assign is_jtype = ~w_empty & w_op_j;
    assign is_itype = ~w_empty & ~w_op_r & ~w_op_j;
`endif

endmodule

// File: tb/tb_instr_queue_splitter.sv
// Directed self-checking bench for instr_queue_splitter (DEPTH=4, PC_W=32, EXT_W=32).
`timescale 1ns/1ps
module tb_instr_queue_splitter;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EXT_W = 32;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        ext_op;
    logic [PC_W-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm16;
    logic [EXT_W-1:0]  imm_ext;
    logic [25:0]       jidx;
    logic [2:0]        count;
`ifdef INSTR_QUEUE_CLASSIFY_EN
    logic              is_rtype;
    logic              is_jtype;
    logic              is_itype;
`endif

    int n_vec;
    int n_err;

    instr_queue_splitter #(.PC_W(PC_W), .DEPTH(DEPTH), .EXT_W(EXT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_op    (ext_op),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .op        (op),
        .funct     (funct),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm16     (imm16),
        .imm_ext   (imm_ext),
        .jidx      (jidx),
`ifdef INSTR_QUEUE_CLASSIFY_EN
        .is_rtype  (is_rtype),
        .is_jtype  (is_jtype),
        .is_itype  (is_itype),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        ext_op    = 2'b00;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #12;
        reset_n = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_vec++; if (imm_ext !== 32'h0) begin n_err++; $display("FAIL reset_imm_ext got %h exp 0", imm_ext); end
        n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
        tick();
        n_vec++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL idle_state got v=%0b c=%0d exp v=0 c=0", out_valid, count); end
    endtask

    task automatic test_push_decode();
        push_one(32'h3000, 32'h2408FFFF);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL push_out_valid got %0b exp 1", out_valid); end
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL push_count got %0d exp 1", count); end
        n_vec++; if (out_pc !== 32'h3000) begin n_err++; $display("FAIL push_out_pc got %h exp 3000", out_pc); end
        n_vec++; if (op !== 6'h09) begin n_err++; $display("FAIL push_op got %h exp 09", op); end
        n_vec++; if (rs !== 5'd0) begin n_err++; $display("FAIL push_rs got %0d exp 0", rs); end
        n_vec++; if (rt !== 5'd8) begin n_err++; $display("FAIL push_rt got %0d exp 8", rt); end
        n_vec++; if (imm16 !== 16'hFFFF) begin n_err++; $display("FAIL push_imm16 got %h exp ffff", imm16); end
        ext_op = 2'b01; #1;
        n_vec++; if (imm_ext !== 32'hFFFFFFFF) begin n_err++; $display("FAIL ext_sign got %h exp ffffffff", imm_ext); end
        ext_op = 2'b00; #1;
        n_vec++; if (imm_ext !== 32'h0000FFFF) begin n_err++; $display("FAIL ext_zero got %h exp 0000ffff", imm_ext); end
        ext_op = 2'b10; #1;
        n_vec++; if (imm_ext !== 32'hFFFF0000) begin n_err++; $display("FAIL ext_upper got %h exp ffff0000", imm_ext); end
        ext_op = 2'b11; #1;
        n_vec++; if (imm_ext !== 32'h0000FFFF) begin n_err++; $display("FAIL ext_mode3 got %h exp 0000ffff", imm_ext); end
        ext_op = 2'b00;
        do_flush();
        n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_one got c=%0d v=%0b exp c=0 v=0", count, out_valid); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            push_one(32'h3000 + 32'(4 * i), 32'h20000000 | 32'(i));
        end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
        push_one(32'h3010, 32'h20000004);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_reject_count got %0d exp 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (out_pc !== 32'h3000 + 32'(4 * i)) begin n_err++; $display("FAIL drain_pc[%0d] got %h exp %h", i, out_pc, 32'h3000 + 32'(4 * i)); end
            n_vec++; if (out_instr !== (32'h20000000 | 32'(i))) begin n_err++; $display("FAIL drain_instr[%0d] got %h exp %h", i, out_instr, 32'h20000000 | 32'(i)); end
            tick();
        end
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL drain_empty got v=%0b c=%0d exp v=0 c=0", out_valid, count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        push_one(32'h4000, 32'h8C000000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_pc    = 32'h4000 + 32'(4 * (k + 1));
            in_instr = 32'h8C000000 | 32'(k + 1);
            n_vec++; if (out_pc !== 32'h4000 + 32'(4 * k) || count !== 3'd1) begin
                n_err++; $display("FAIL stream[%0d] got pc=%h c=%0d exp pc=%h c=1", k, out_pc, count, 32'h4000 + 32'(4 * k));
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (out_instr !== 32'h8C000014 || count !== 3'd1) begin n_err++; $display("FAIL stream_last got i=%h c=%0d exp i=8c000014 c=1", out_instr, count); end
        tick();
        out_ready = 1'b0;
        n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty got c=%0d v=%0b exp c=0 v=0", count, out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            push_one(32'h5000 + 32'(4 * i), 32'h24000000 | 32'(i));
        end
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL preflush_count got %0d exp 3", count); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h6000;
        in_instr  = 32'h24006000;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", count); end
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_flags got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready); end
        push_one(32'h5555, 32'h24005555);
        n_vec++; if (out_pc !== 32'h5555 || count !== 3'd1) begin n_err++; $display("FAIL postflush_head got pc=%h c=%0d exp pc=5555 c=1", out_pc, count); end
        do_flush();
    endtask

    task automatic test_async_reset();
        push_one(32'h7000, 32'h3C08ABCD);
        push_one(32'h7004, 32'h3C09BEEF);
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL prereset_count got %0d exp 2", count); end
        ext_op = 2'b01;
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
            n_err++; $display("FAIL areset_flags got v=%0b r=%0b c=%0d exp v=0 r=1 c=0", out_valid, in_ready, count);
        end
        n_vec++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_err++; $display("FAIL areset_head got pc=%h i=%h exp 0 0", out_pc, out_instr); end
        n_vec++; if (op !== 6'h0 || rt !== 5'd0 || imm16 !== 16'h0 || imm_ext !== 32'h0) begin
            n_err++; $display("FAIL areset_fields got op=%h rt=%0d imm=%h ext=%h exp 0", op, rt, imm16, imm_ext);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ext_op  = 2'b00;
        tick();
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL postreset_count got %0d exp 0", count); end
    endtask

    task automatic test_classify();
        push_one(32'h8000, 32'h01095021);
        push_one(32'h8004, 32'h0C000C00);
        n_vec++; if (rd !== 5'd10 || funct !== 6'h21) begin n_err++; $display("FAIL add_fields got rd=%0d f=%h exp rd=10 f=21", rd, funct); end
        n_vec++; if (rs !== 5'd8 || rt !== 5'd9 || shamt !== 5'd0) begin n_err++; $display("FAIL add_regs got rs=%0d rt=%0d sh=%0d exp 8 9 0", rs, rt, shamt); end
`ifdef INSTR_QUEUE_CLASSIFY_EN
        n_vec++; if ({is_rtype, is_jtype, is_itype} !== 3'b100) begin n_err++; $display("FAIL add_class got %b exp 100", {is_rtype, is_jtype, is_itype}); end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (op !== 6'h03 || jidx !== 26'h0000C00) begin n_err++; $display("FAIL jal_fields got op=%h j=%h exp op=03 j=0000c00", op, jidx); end
`ifdef INSTR_QUEUE_CLASSIFY_EN
        n_vec++; if ({is_rtype, is_jtype, is_itype} !== 3'b010) begin n_err++; $display("FAIL jal_class got %b exp 010", {is_rtype, is_jtype, is_itype}); end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL class_empty got %0b exp 0", out_valid); end
`ifdef INSTR_QUEUE_CLASSIFY_EN
        n_vec++; if ({is_rtype, is_jtype, is_itype} !== 3'b000) begin n_err++; $display("FAIL empty_class got %b exp 000", {is_rtype, is_jtype, is_itype}); end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_push_decode();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_classify();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
